// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter.
// Holds the FSM state encoding, the grant-select constants, the default
// wait limit, the registered memory command payload and the 32-bit 2:1 mux
// used for all select/data steering.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned WAIT_W       = 8;
    localparam int unsigned MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    // Command presented to the shared memory for one transaction
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // 32-bit 2:1 mux: sel 0 -> a0, sel 1 -> a1
    function automatic logic [DATA_W-1:0] mux2_32(
        input logic              sel,
        input logic [DATA_W-1:0] a0,
        input logic [DATA_W-1:0] a1
    );
        return sel ? a1 : a0;
    endfunction

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_arb_timer.sv
// Memory-wait counter with timeout compare.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-low reset
//   busy_i     - arbiter is in a BUSY_* state this cycle
//   timeout_c  - combinational: this is the MAX_WAIT-th busy cycle
// The counter is zero on the first busy cycle and clears whenever the
// arbiter leaves BUSY_*, so every transaction starts from a fresh count.
module mem_arb_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    output logic timeout_c
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Count busy cycles; clear otherwise
    always_comb begin
        cnt_d = '0;
        if (busy_i) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_c = busy_i && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule : mem_arb_timer

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a data port.
// Ports:
//   clk_i, rst_i                        - clock, async active-low reset
//   if_req_i, if_addr_i                 - fetch request / word address
//   if_ack_o, if_rdata_o                - fetch completion pulse / read data
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                          - data request / we / addr / wdata
//   dm_ack_o, dm_rdata_o                - data completion pulse / read data
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                         - shared memory command
//   mem_ack_i, mem_rdata_i              - memory completion / read data
//   sel_o                               - address-mux select (0 fetch, 1 data)
//   stall_o                             - combinational pipeline stall
//   err_o                               - one-cycle timeout pulse
// Build option: MEM_ARB_ROUND_ROBIN_EN makes simultaneous requests alternate
// through a last-grant register; otherwise data always beats fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              sel_o,
    output logic              stall_o,
    output logic              err_o
);

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              mem_req_q, mem_req_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;

    logic              busy_c;
    logic              timeout_c;
    logic              grant_sel_c;
    logic [DATA_W-1:0] resp_data_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;
`endif

    assign busy_c = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_DM);

    mem_arb_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .busy_i    (busy_c),
        .timeout_c (timeout_c)
    );

    // Winner among the current requests (only used in IDLE)
    always_comb begin
        grant_sel_c = dm_req_i ? SEL_DM : SEL_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (if_req_i && dm_req_i) begin
            grant_sel_c = (last_grant_q == SEL_IF) ? SEL_DM : SEL_IF;
        end
`endif
    end

    // Read data returned on completion: zero on writes and on timeout
    assign resp_data_c = mux2_32(mem_ack_i && !cmd_q.we, '0, mem_rdata_i);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cmd_d      = cmd_q;
        mem_req_d  = mem_req_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = '0;
        dm_rdata_d = '0;
        err_d      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    sel_d       = grant_sel_c;
                    cmd_d.addr  = mux2_32(grant_sel_c, if_addr_i, dm_addr_i);
                    cmd_d.wdata = mux2_32(grant_sel_c, '0, dm_wdata_i);
                    cmd_d.we    = (grant_sel_c == SEL_DM) && dm_we_i;
                    mem_req_d   = 1'b1;
                    state_d     = (grant_sel_c == SEL_DM) ? ST_BUSY_DM : ST_BUSY_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    // Only contention moves the pointer, so a lone request
                    // never steals the other side's turn
                    if (if_req_i && dm_req_i) begin
                        last_grant_d = grant_sel_c;
                    end
`endif
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                // mem_ack_i has priority over a same-cycle timeout
                if (mem_ack_i || timeout_c) begin
                    mem_req_d = 1'b0;
                    err_d     = !mem_ack_i;
                    state_d   = ST_RESP;
                    if (state_q == ST_BUSY_DM) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = resp_data_c;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = resp_data_c;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_IF;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Reset to fetch-granted-last so data wins the first contention
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= SEL_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;
    assign sel_o       = sel_q;
    assign err_o       = err_q;

    assign stall_o = (if_req_i && !if_ack_q) || (dm_req_i && !dm_ack_q);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build).
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        sel_o;
    logic        stall_o;
    logic        err_o;

    int passed = 0;
    int total  = 0;
    int req_cycles;

    mem_port_arbiter #(
        .MAX_WAIT (15)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_ack_o    (dm_ack_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .sel_o       (sel_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"},   32'(mem_req_o),  32'h0);
        chk({tag, ".mem_we"},    32'(mem_we_o),   32'h0);
        chk({tag, ".mem_addr"},  mem_addr_o,      32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata_o,     32'h0);
        chk({tag, ".sel"},       32'(sel_o),      32'h0);
        chk({tag, ".if_ack"},    32'(if_ack_o),   32'h0);
        chk({tag, ".dm_ack"},    32'(dm_ack_o),   32'h0);
        chk({tag, ".if_rdata"},  if_rdata_o,      32'h0);
        chk({tag, ".dm_rdata"},  dm_rdata_o,      32'h0);
        chk({tag, ".err"},       32'(err_o),      32'h0);
    endtask

    initial begin
        rst_i       = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_addr_i   = 32'h0;
        dm_wdata_i  = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        chk("reset.stall", 32'(stall_o), 32'h0);
        rst_i = 1'b1;
        tick();

        // Fetch read, ack after two wait cycles
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        #1;
        chk("if.stall_req", 32'(stall_o), 32'h1);
        req_cycles = 0;
        tick();
        chk("if.mem_req1", 32'(mem_req_o), 32'h1);
        chk("if.addr",     mem_addr_o,     32'h0000_0100);
        chk("if.sel",      32'(sel_o),     32'h0);
        chk("if.we",       32'(mem_we_o),  32'h0);
        req_cycles += 32'(mem_req_o);
        tick();
        chk("if.mem_req2", 32'(mem_req_o), 32'h1);
        chk("if.no_ack",   32'(if_ack_o),  32'h0);
        req_cycles += 32'(mem_req_o);
        tick();
        req_cycles += 32'(mem_req_o);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        chk("if.req_cycles", 32'(req_cycles), 32'd3);
        chk("if.mem_req_drop", 32'(mem_req_o), 32'h0);
        chk("if.ack",      32'(if_ack_o),  32'h1);
        chk("if.rdata",    if_rdata_o,     32'hDEAD_BEEF);
        chk("if.sel_hold", 32'(sel_o),     32'h0);
        chk("if.stall_ack", 32'(stall_o),  32'h0);
        chk("if.no_err",   32'(err_o),     32'h0);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        if_req_i    = 1'b0;
        tick();
        chk("if.ack_pulse", 32'(if_ack_o), 32'h0);
        chk("if.idle_req",  32'(mem_req_o), 32'h0);

        // Contention: data first, then fetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0300;
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h0000_0400;
        tick();
        chk("arb.sel_dm",  32'(sel_o),     32'h1);
        chk("arb.addr_dm", mem_addr_o,     32'h0000_0400);
        chk("arb.stall",   32'(stall_o),   32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hAAAA_5555;
        tick();
        chk("arb.dm_ack",   32'(dm_ack_o), 32'h1);
        chk("arb.dm_rdata", dm_rdata_o,    32'hAAAA_5555);
        chk("arb.if_noack", 32'(if_ack_o), 32'h0);
        chk("arb.stall_if", 32'(stall_o),  32'h1);
        mem_ack_i = 1'b0;
        dm_req_i  = 1'b0;
        tick();
        chk("arb.idle_req", 32'(mem_req_o), 32'h0);
        tick();
        chk("arb.sel_if",  32'(sel_o),     32'h0);
        chk("arb.addr_if", mem_addr_o,     32'h0000_0300);
        chk("arb.req_if",  32'(mem_req_o), 32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        tick();
        chk("arb.if_ack",   32'(if_ack_o), 32'h1);
        chk("arb.if_rdata", if_rdata_o,    32'h1111_2222);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();

        // Data write: read data must come back as zero
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h0000_0200;
        dm_wdata_i = 32'h1234_5678;
        tick();
        chk("wr.we",    32'(mem_we_o), 32'h1);
        chk("wr.wdata", mem_wdata_o,   32'h1234_5678);
        chk("wr.addr",  mem_addr_o,    32'h0000_0200);
        chk("wr.sel",   32'(sel_o),    32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        chk("wr.ack",   32'(dm_ack_o), 32'h1);
        chk("wr.rdata", dm_rdata_o,    32'h0);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        tick();

        // Timeout after 15 busy cycles without ack
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0000_0500;
        mem_rdata_i = 32'h5A5A_5A5A;
        tick();
        req_cycles = 32'(mem_req_o);
        for (int i = 0; i < 14; i++) begin
            chk("to.no_err", 32'(err_o), 32'h0);
            tick();
            req_cycles += 32'(mem_req_o);
        end
        chk("to.req_cycles", 32'(req_cycles), 32'd15);
        tick();
        chk("to.err",      32'(err_o),     32'h1);
        chk("to.ack",      32'(if_ack_o),  32'h1);
        chk("to.rdata",    if_rdata_o,     32'h0);
        chk("to.req_drop", 32'(mem_req_o), 32'h0);
        if_req_i    = 1'b0;
        mem_rdata_i = 32'h0;
        tick();
        chk("to.err_pulse", 32'(err_o),    32'h0);
        chk("to.ack_pulse", 32'(if_ack_o), 32'h0);
        tick();
        chk("to.idle", 32'(mem_req_o), 32'h0);

        // Reset during BUSY_DM, then a late ack
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h0000_0600;
        dm_wdata_i = 32'hCAFE_F00D;
        tick();
        chk("rst.busy_req", 32'(mem_req_o), 32'h1);
        #2;
        rst_i = 1'b0;
        #1;
        chk_all_zero("rst.async");
        dm_req_i  = 1'b0;
        dm_we_i   = 1'b0;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        tick();
        #3;
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.no_dm_ack", 32'(dm_ack_o),  32'h0);
            chk("rst.no_req",    32'(mem_req_o), 32'h0);
            chk("rst.no_err",    32'(err_o),     32'h0);
        end
        mem_ack_i = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the number of memory-wait cycles before timeout; legal range 1..255.
REQ-002 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  SHALL be the reset, asynchronous assert, active-low.
REQ-004 if_req_i in 1 / if_addr_i in 32 SHALL be the fetch request and word address; held by requester until if_ack_o.
REQ-005 if_ack_o out 1 / if_rdata_o out 32 SHALL be the one-cycle fetch completion pulse and read data.
REQ-006 dm_req_i in 1 / dm_we_i in 1 / dm_addr_i in 32 / dm_wdata_i in 32 SHALL be the data request, write enable, address and write data; held until dm_ack_o.
REQ-007 dm_ack_o out 1 / dm_rdata_o out 32 SHALL be the one-cycle data completion pulse and read data (0 on writes).
REQ-008 mem_req_o out 1 / mem_we_o out 1 / mem_addr_o out 32 / mem_wdata_o out 32 SHALL drive the shared single-port memory.
REQ-009 mem_ack_i in 1 / mem_rdata_i in 32 SHALL be the memory completion strobe and read data.
REQ-010 sel_o out 1 SHALL be the address-mux select (0 = fetch, 1 = data), held stable for a whole transaction.
REQ-011 stall_o out 1 SHALL signal pipeline stall; err_o out 1 SHALL pulse one cycle on timeout.

Function
REQ-012 FSM states SHALL be IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-013 In IDLE with any request sampled at edge N, the arbiter SHALL register the winner's address/we/wdata, set sel_o, and enter BUSY_*; mem_req_o SHALL be high from cycle N+1.
REQ-014 Default arbitration SHALL be fixed priority: data over fetch when both request in the same cycle.
REQ-015 In BUSY_*, mem_req_o and all mem_* outputs SHALL stay constant until mem_ack_i is sampled high.
REQ-016 On mem_ack_i at edge M, mem_req_o SHALL drop at M+1, read data SHALL be registered, and the granted ack_o SHALL pulse exactly in cycle M+1 (state RESP).
REQ-017 RESP SHALL return to IDLE unconditionally; minimum spacing between grants is therefore 3 cycles, and the ungranted requester SHALL be served next.
REQ-018 A wait counter (8 bits) SHALL count BUSY_* cycles; reaching MAX_WAIT without mem_ack_i SHALL force RESP with rdata = 32'h0 and err_o high for that cycle.
REQ-019 mem_ack_i outside BUSY_* SHALL be ignored.
REQ-020 stall_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-021 Requests dropped by the requester mid-transaction SHALL NOT abort the memory cycle; the ack pulse is still produced.

Reset
REQ-022 While rst_i is low: state IDLE, sel_o 0, mem_req_o 0, mem_we_o 0, all 32-bit outputs 0, acks 0, err_o 0, wait counter 0, round-robin pointer 0.
REQ-023 Reset asserted mid-transaction SHALL abandon it with no ack pulse after release.

Configuration
REQ-024 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL alternate, using a 1-bit last-grant register (reset value 0 = fetch granted last, so data wins first).
REQ-025 Macro undefined: fixed data-over-fetch priority per REQ-014; no last-grant register exists.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding, the grant-select constants SEL_IF=0/SEL_DM=1, and the default MAX_WAIT.
REQ-027 One sub-module, mem_arb_timer (wait counter + timeout compare), SHALL be instantiated; the select and data steering SHALL use the existing 32-bit 2:1 mux.

Verification
REQ-028 if_req_i=1 addr 0x100, mem_ack_i after 2 wait cycles with rdata 0xDEADBEEF -> mem_req_o high 3 cycles, if_ack_o pulse 1 cycle later with 0xDEADBEEF, sel_o=0 throughout.
REQ-029 if_req_i and dm_req_i rise together, no macro -> data served first (sel_o=1), fetch granted in IDLE after RESP; with MEM_ARB_ROUND_ROBIN_EN second contention -> fetch first.
REQ-030 dm_we_i=1 addr 0x200 wdata 0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678, dm_ack_o pulse, dm_rdata_o=0.
REQ-031 No mem_ack_i for MAX_WAIT=15 cycles -> err_o and ack pulse in same cycle, rdata 0, state returns to IDLE.
REQ-032 rst_i low during BUSY_DM -> all outputs 0 asynchronously, no dm_ack_o after release; late mem_ack_i ignored.
